// File: rtl/rr_req_agent.sv
// rr_req_agent: requester-side agent for the round-robin arbiter.
// It buffers upstream beats in a FIFO and holds a registered request toward the arbiter.
// Each granted cycle pops one beat onto the shared bus, registered.
// It also flags grant starvation and grants that arrive while not requesting.
module rr_req_agent #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PKT_MODE   = 0,
  parameter int unsigned STARVE_MAX = 255
) (
  input  logic                       sys_clk_i,
  input  logic                       rst_n_i,
  input  logic                       s_valid_i,
  output logic                       s_ready_o,
  input  logic [DATA_W-1:0]          s_data_i,
  input  logic                       s_last_i,
  output logic                       request_o,
  input  logic                       grant_i,
  output logic                       bus_valid_o,
  output logic [DATA_W-1:0]          bus_data_o,
  output logic                       bus_last_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       starve_o,
  input  logic                       starve_clr_i,
  output logic                       grant_err_o
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned CW  = 16;
  localparam int unsigned EW  = DATA_W + 1;
  localparam bit          PKT = (PKT_MODE != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LOCK = 2'd2
  } state_e;

  logic [EW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q, level_d;
  logic [LW-1:0]     pkt_cnt_q, pkt_cnt_d;
  state_e            state_q, state_d;
  logic              request_q;
  logic              bus_valid_q;
  logic [DATA_W-1:0] bus_data_q;
  logic              bus_last_q;
  logic [CW-1:0]     starve_cnt_q, starve_cnt_d;
  logic              starve_q, starve_d;
  logic              grant_err_q;

  logic              push, pop;
  logic [EW-1:0]     head;
  logic              head_last;
  logic              eligible;
  logic              starve_set;

  assign s_ready_o = (level_q < LW'(DEPTH));
  assign push      = s_valid_i && s_ready_o;
  assign pop       = request_q && grant_i && (level_q != '0);
  assign head      = mem_q[rd_ptr_q];
  assign head_last = head[DATA_W];

  // Next-cycle occupancy and complete-packet count
  always_comb begin
    level_d   = level_q + LW'(push) - LW'(pop);
    pkt_cnt_d = pkt_cnt_q + LW'(push && s_last_i) - LW'(pop && head_last);
    eligible  = PKT ? (pkt_cnt_d != '0) : (level_d != '0);
  end

  // Request FSM next state; LOCK holds the arbiter until a packet's last beat leaves
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (eligible) state_d = REQ;
      end
      REQ: begin
        if (PKT && pop && !head_last) state_d = LOCK;
        else if (!eligible)           state_d = IDLE;
      end
      LOCK: begin
        if (pop && head_last) state_d = eligible ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Starvation counter saturates; the set term beats a simultaneous clear
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if ((state_q == IDLE) || grant_i) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < CW'(STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end
    starve_set = (state_q != IDLE) && !grant_i && (starve_cnt_d == CW'(STARVE_MAX));
    starve_d   = starve_q;
    if (starve_set)        starve_d = 1'b1;
    else if (starve_clr_i) starve_d = 1'b0;
  end

  // FIFO storage; payload needs no reset since pointers gate visibility
  always_ff @(posedge sys_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {s_last_i, s_data_i};
  end

  // FIFO pointers, counters and FSM state
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      pkt_cnt_q    <= '0;
      state_q      <= IDLE;
      request_q    <= 1'b0;
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
      grant_err_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q      <= level_d;
      pkt_cnt_q    <= pkt_cnt_d;
      state_q      <= state_d;
      request_q    <= (state_d != IDLE);
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= starve_d;
      if (grant_i && !request_q) grant_err_q <= 1'b1;
    end
  end

  // Shared-bus output register; payload holds when no beat is popped
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bus_valid_q <= 1'b0;
      bus_data_q  <= '0;
      bus_last_q  <= 1'b0;
    end else begin
      bus_valid_q <= pop;
      if (pop) begin
        bus_data_q <= head[DATA_W-1:0];
        bus_last_q <= head_last;
      end
    end
  end

  assign request_o   = request_q;
  assign bus_valid_o = bus_valid_q;
  assign bus_data_o  = bus_data_q;
  assign bus_last_o  = bus_last_q;
  assign level_o     = level_q;
  assign starve_o    = starve_q;
  assign grant_err_o = grant_err_q;

endmodule
